// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int unsigned NSTEPS = 4;
    localparam int unsigned MAXW   = 64;

    // Magnitude of a w-bit value held in the low bits of x; the caller truncates to w bits.
    function automatic logic [MAXW-1:0] vabs(input logic [MAXW-1:0] x, input logic sgn,
                                             input int unsigned w);
        if (sgn && x[w-1]) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational unsigned N x N Urdhva-Tiryagbhyam multiplier, recursively decomposed.
module vedic_core #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    if (N == 2) begin : g_base
        logic t1, t2, t3, c1;
        assign t1   = a[1] & b[0];
        assign t2   = a[0] & b[1];
        assign t3   = a[1] & b[1];
        assign c1   = t1 & t2;
        assign p[0] = a[0] & b[0];
        assign p[1] = t1 ^ t2;
        assign p[2] = t3 ^ c1;
        assign p[3] = t3 & c1;
    end else begin : g_split
        localparam int unsigned M = N / 2;
        logic [N-1:0] ll, hl, lh, hh;

        vedic_core #(.N(M)) u_ll (.a(a[M-1:0]), .b(b[M-1:0]), .p(ll));
        vedic_core #(.N(M)) u_hl (.a(a[N-1:M]), .b(b[M-1:0]), .p(hl));
        vedic_core #(.N(M)) u_lh (.a(a[M-1:0]), .b(b[N-1:M]), .p(lh));
        vedic_core #(.N(M)) u_hh (.a(a[N-1:M]), .b(b[N-1:M]), .p(hh));

        assign p = (2*N)'(ll) + ((2*N)'(hl) << M) + ((2*N)'(lh) << M) + ((2*N)'(hh) << N);
    end

endmodule

// File: rtl/vedic_mult_seq.sv
// Multi-cycle WIDTH x WIDTH multiplier reusing one WIDTH/2 Vedic core over four steps.
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned SW = $clog2(NSTEPS);

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] out_p_q, out_p_d;

    logic [H-1:0]       core_x, core_y;
    logic [WIDTH-1:0]   core_p;
    logic [2*WIDTH-1:0] pp_sh, sum;
    logic               accept, sgn;

    // Step bit 0 selects the high half of a, bit 1 the high half of b.
    assign core_x = step_q[0] ? a_q[WIDTH-1:H] : a_q[H-1:0];
    assign core_y = step_q[1] ? b_q[WIDTH-1:H] : b_q[H-1:0];

    vedic_core #(.N(H)) u_core (.a(core_x), .b(core_y), .p(core_p));

    always_comb begin
        pp_sh = (2*WIDTH)'(core_p);
        case (step_q)
            2'd1, 2'd2: pp_sh = (2*WIDTH)'(core_p) << H;
            2'd3:       pp_sh = (2*WIDTH)'(core_p) << (2*H);
            default:    pp_sh = (2*WIDTH)'(core_p);
        endcase
    end

    assign sum       = acc_q + pp_sh;
    assign in_ready  = ena & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign sgn       = SIGNED_EN & in_signed;
    assign out_valid = (state_q == DONE);
    assign out_p     = out_p_q;
    assign busy      = (state_q == MUL);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        if (ena) begin
            case (state_q)
                MUL: begin
                    acc_d  = sum;
                    step_d = step_q + 1'b1;
                    if (step_q == SW'(NSTEPS - 1)) begin
                        out_p_d = sign_q ? -sum : sum;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
            // A DONE consume and a new accept may coincide; the accept wins.
            if (accept) begin
                a_d     = WIDTH'(vabs(MAXW'(in_a), sgn, WIDTH));
                b_d     = WIDTH'(vabs(MAXW'(in_b), sgn, WIDTH));
                sign_d  = sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                acc_d   = '0;
                step_d  = '0;
                state_d = MUL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed self-checking bench for vedic_mult_seq (WIDTH=8 signed/unsigned-only, WIDTH=4 exhaustive).
module tb_vedic_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, in_valid, in_signed, out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_p;

    logic        u_in_valid, u_in_signed, u_in_ready, u_out_valid, u_busy;
    logic [7:0]  u_in_a, u_in_b;
    logic [15:0] u_out_p;

    logic        f_in_valid, f_in_signed, f_in_ready, f_out_valid, f_busy;
    logic [3:0]  f_in_a, f_in_b;
    logic [7:0]  f_out_p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vedic_mult_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    vedic_mult_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .in_a(u_in_a), .in_b(u_in_b), .in_signed(u_in_signed), .out_valid(u_out_valid),
        .out_ready(1'b1), .out_p(u_out_p), .busy(u_busy)
    );

    vedic_mult_seq #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_a(f_in_a), .in_b(f_in_b), .in_signed(f_in_signed), .out_valid(f_out_valid),
        .out_ready(1'b1), .out_p(f_out_p), .busy(f_busy)
    );

    // Accept one operation on the main DUT, then count enabled edges until out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [15:0] p, output int lat);
        int k;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_signed = ~s;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        p = out_p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        u_in_valid = 1'b0; u_in_signed = 1'b0; u_in_a = '0; u_in_b = '0;
        f_in_valid = 1'b0; f_in_signed = 1'b0; f_in_a = '0; f_in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_p !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_p=%h busy=%b, expected 0 0000 0", out_valid, out_p, busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] p;
        int lat;
        run_op(8'hFF, 8'hFF, 1'b0, p, lat);
        checks++;
        if (p !== 16'hFE01) begin
            errors++;
            $display("FAIL ff_x_ff: got %h expected fe01", p);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL ff_x_ff_latency: got %0d expected 4", lat);
        end
        run_op(8'h7F, 8'h81, 1'b0, p, lat);
        checks++;
        if (p !== 16'h3FFF) begin
            errors++;
            $display("FAIL 7f_x_81_unsigned: got %h expected 3fff", p);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [5] = '{8'h80, 8'h80, 8'hFF, 8'h7F, 8'h00};
        logic [7:0]  vb [5] = '{8'h80, 8'h01, 8'h02, 8'h81, 8'hFF};
        logic [15:0] ve [5] = '{16'h4000, 16'hFF80, 16'hFFFE, 16'hC0FF, 16'h0000};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], 1'b1, p, lat);
            checks++;
            if (p !== ve[i] || lat !== 4) begin
                errors++;
                $display("FAIL signed_%h_x_%h: got %h lat %0d expected %h lat 4", va[i], vb[i], p, lat, ve[i]);
            end
        end
    endtask

    task automatic test_signed_disabled();
        int k;
        u_in_a = 8'hFF; u_in_b = 8'h02; u_in_signed = 1'b1; u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        k = 0;
        while (u_out_valid !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (u_out_p !== 16'h01FE || k !== 4) begin
            errors++;
            $display("FAIL signed_en0_ff_x_02: got %h lat %0d expected 01fe lat 4", u_out_p, k);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        int lat;
        int bad;
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, p, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_p !== 16'h03A8 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d bad cycles, out_valid=%b out_p=%h in_ready=%b, expected 1 03a8 0", bad, out_valid, out_p, in_ready);
        end
        out_ready = 1'b1; in_a = 8'h05; in_b = 8'h06; in_signed = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_accept: out_valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_p !== 16'h001E || lat !== 4) begin
            errors++;
            $display("FAIL back_to_back: got %h lat %0d expected 001e lat 4", out_p, lat);
        end
    endtask

    task automatic test_enable();
        int lat;
        int k;
        @(posedge clk); #1;
        in_a = 8'h0B; in_b = 8'h0D; in_signed = 1'b0; in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        ena = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ena_freeze: busy=%b out_valid=%b in_ready=%b expected 1 0 0", busy, out_valid, in_ready);
        end
        ena = 1'b1;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_p !== 16'h008F || lat !== 7) begin
            errors++;
            $display("FAIL ena_stall: got %h lat %0d expected 008f lat 7", out_p, lat);
        end
        ena = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ena_in_ready: got %b expected 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_p !== 16'h008F) begin
            errors++;
            $display("FAIL ena_out_ready_ignored: out_valid=%b out_p=%h expected 1 008f", out_valid, out_p);
        end
        ena = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [15:0] p;
        int lat;
        int bad;
        in_a = 8'h55; in_b = 8'h33; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_p !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: out_valid=%b out_p=%h busy=%b expected 0 0000 0", out_valid, out_p, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_result: out_valid high %0d cycles, expected 0", bad);
        end
        run_op(8'h55, 8'h33, 1'b0, p, lat);
        checks++;
        if (p !== 16'h10EF || lat !== 4) begin
            errors++;
            $display("FAIL post_reset_op: got %h lat %0d expected 10ef lat 4", p, lat);
        end
    endtask

    task automatic test_width4_exhaustive();
        int k;
        int ia, ib;
        logic [7:0] exp;
        int bad;
        bad = 0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ia = (s == 1 && a >= 8) ? a - 16 : a;
                    ib = (s == 1 && b >= 8) ? b - 16 : b;
                    exp = 8'(ia * ib);
                    f_in_a = 4'(a); f_in_b = 4'(b); f_in_signed = (s == 1); f_in_valid = 1'b1;
                    k = 0;
                    while (f_in_ready !== 1'b1 && k < 50) begin
                        @(posedge clk); #1; k++;
                    end
                    @(posedge clk); #1;
                    f_in_valid = 1'b0;
                    k = 0;
                    while (f_out_valid !== 1'b1 && k < 50) begin
                        @(posedge clk); #1; k++;
                    end
                    checks++;
                    if (f_out_p !== exp || k !== 4) begin
                        errors++;
                        bad++;
                        if (bad <= 10)
                            $display("FAIL w4_s%0d_%0d_x_%0d: got %h lat %0d expected %h lat 4", s, a, b, f_out_p, k, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_signed_disabled();
        test_backpressure();
        test_enable();
        test_reset_abort();
        test_width4_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
